aes128_decryptor: RTL and testbench

Iterative AES-128 decryptor (FIPS-197 inverse cipher), the receive-side counterpart of the existing `encryptor` block. It accepts a 128-bit ciphertext and 128-bit cipher key, expands the key schedule on-chip and runs one inverse round per clock. It returns the 128-bit plaintext with a one-cycle `done` pulse. It sits after the link/storage path wherever encrypted blocks must be recovered, and shares the encryptor's byte ordering so a loopback of encryptor→decryptor is identity.

---
 rtl/aes128_decryptor.sv | 228 ++++++++++++++++++++++
 tb/tb_aes128_decryptor.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_decryptor.sv
// Iterative AES-128 inverse cipher: on-chip key expansion, then one inverse round per clock.
// Optional feature macro AES_DEC_KEYREUSE_EN: reuse the last expanded key schedule when the key repeats.
module aes128_decryptor (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] ciphertext,
   input  logic [127:0] key,
   output logic [127:0] plaintext,
   output logic         done,
   output logic         busy
);

   typedef enum logic [2:0] {IDLE, EXPAND, INIT, ROUND, FINAL} state_e;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, t;
      p = 8'h00;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = xtime(t);
      end
      return p;
   endfunction

   // x^254 is the multiplicative inverse and conveniently maps 0 to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] x2, x3, x12, x15, t;
      x2  = gf_mul(x, x);
      x3  = gf_mul(x2, x);
      t   = gf_mul(x3, x3);
      x12 = gf_mul(t, t);
      x15 = gf_mul(x12, x3);
      t   = gf_mul(x15, x15);
      t   = gf_mul(t, t);
      t   = gf_mul(t, t);
      t   = gf_mul(t, t);
      t   = gf_mul(t, x12);
      return gf_mul(t, x2);
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] x;
      x = gf_inv(b);
      return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] s);
      return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
   endfunction

   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
         o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
         o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
         o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
      end
      return o;
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] i);
      case (i)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [127:0] key_expand(input logic [127:0] prev, input logic [7:0] rc);
      logic [31:0] t, w0, w1, w2, w3;
      t  = {sbox(prev[23:16]), sbox(prev[15:8]), sbox(prev[7:0]), sbox(prev[31:24])} ^ {rc, 24'h0};
      w0 = prev[127:96] ^ t;
      w1 = prev[95:64]  ^ w0;
      w2 = prev[63:32]  ^ w1;
      w3 = prev[31:0]   ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   state_e       state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [127:0] st_q, st_d;
   logic [127:0] pt_q, pt_d;
   logic         done_q, done_d;
   logic         busy_q, busy_d;
   logic [127:0] rk_q [0:10];
   logic [127:0] rk_d [0:10];
   logic [127:0] sb;

`ifdef AES_DEC_KEYREUSE_EN
   logic key_valid_q, key_valid_d;
   logic key_hit;
   assign key_hit = key_valid_q && (key == rk_q[0]);
`endif

   // ROUND and FINAL both begin with InvShiftRows then InvSubBytes; one shared datapath.
   assign sb = inv_sub_bytes(inv_shift_rows(st_q));

   always_comb begin
      // NOTE: every _d gets a default before the case so no path leaves one unassigned (no latches).
      state_d = state_q;
      cnt_d   = cnt_q;
      st_d    = st_q;
      pt_d    = pt_q;
      done_d  = 1'b0;
      busy_d  = busy_q;
      rk_d    = rk_q;
`ifdef AES_DEC_KEYREUSE_EN
      key_valid_d = key_valid_q;
`endif
      unique case (state_q)
         IDLE: begin
            busy_d = start;
            if (start) begin
               st_d = ciphertext;
`ifdef AES_DEC_KEYREUSE_EN
               if (key_hit) begin
                  state_d = INIT;
               end else begin
                  rk_d[0]     = key;
                  cnt_d       = 4'd1;
                  key_valid_d = 1'b0;
                  state_d     = EXPAND;
               end
`else
               rk_d[0] = key;
               cnt_d   = 4'd1;
               state_d = EXPAND;
`endif
            end
         end
         EXPAND: begin
            rk_d[cnt_q] = key_expand(rk_q[cnt_q - 4'd1], rcon(cnt_q));
            if (cnt_q == 4'd10) begin
               state_d = INIT;
`ifdef AES_DEC_KEYREUSE_EN
               key_valid_d = 1'b1;
`endif
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         INIT: begin
            st_d    = st_q ^ rk_q[10];
            cnt_d   = 4'd9;
            state_d = ROUND;
         end
         ROUND: begin
            st_d  = inv_mix_columns(sb ^ rk_q[cnt_q]);
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = FINAL;
         end
         FINAL: begin
            // The counter has reached 0 here, so rk_q[cnt_q] is rk[0].
            pt_d    = sb ^ rk_q[cnt_q];
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         st_q    <= '0;
         pt_q    <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         // NOTE: the round-key file is reset because a cleared schedule is part of the defined reset state.
         for (int i = 0; i <= 10; i++) rk_q[i] <= '0;
`ifdef AES_DEC_KEYREUSE_EN
         key_valid_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         st_q    <= st_d;
         pt_q    <= pt_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         rk_q    <= rk_d;
`ifdef AES_DEC_KEYREUSE_EN
         key_valid_q <= key_valid_d;
`endif
      end
   end

   assign plaintext = pt_q;
   assign done      = done_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_aes128_decryptor.sv
// Directed bench for aes128_decryptor: FIPS-197 vectors, latency, ignored starts, reset abort, loopback, key reuse.
module tb_aes128_decryptor;

   logic         clk, rst, start, done, busy;
   logic [127:0] ciphertext, key, plaintext;
   int           n_cmp, n_bad;
   logic [7:0]   sbox_t [256];

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] LB_KEY = 128'h6d65677361797372617772746f796f75;
   localparam logic [127:0] LB_PT  = 128'h69206c6f766520636f6d706172636821;
`ifdef AES_DEC_KEYREUSE_EN
   localparam int REUSE_LAT = 11;
`else
   localparam int REUSE_LAT = 21;
`endif

   aes128_decryptor dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .ciphertext (ciphertext),
      .key        (key),
      .plaintext  (plaintext),
      .done       (done),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: carry-less product reduced modulo 0x11B.
   function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
      logic [14:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({7'b0, a} << i);
      for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h011b << (i - 8));
      return p[7:0];
   endfunction

   task automatic build_sbox();
      logic [7:0] inv, c;
      c = 8'h63;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (tb_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         for (int i = 0; i < 8; i++)
            sbox_t[x][i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      end
   endtask

   // Forward cipher standing in for the encryptor block in the loopback test.
   function automatic logic [127:0] tb_encrypt(input logic [127:0] pt, input logic [127:0] k);
      logic [31:0]  w [44];
      logic [31:0]  t;
      logic [7:0]   rc;
      logic [127:0] s, o;
      logic [7:0]   a [4];
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = {t[23:0], t[31:24]};
            t  = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
            rc = tb_mul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      s = pt ^ {w[0], w[1], w[2], w[3]};
      for (int r = 1; r <= 10; r++) begin
         for (int n = 0; n < 16; n++) s[127-8*n -: 8] = sbox_t[s[127-8*n -: 8]];
         for (int c = 0; c < 4; c++)
            for (int q = 0; q < 4; q++)
               o[127-8*(4*c+q) -: 8] = s[127-8*(4*((c+q)%4)+q) -: 8];
         s = o;
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               for (int q = 0; q < 4; q++) a[q] = s[127-32*c-8*q -: 8];
               s[127-32*c -: 8] = tb_mul(a[0], 8'h02) ^ tb_mul(a[1], 8'h03) ^ a[2] ^ a[3];
               s[119-32*c -: 8] = a[0] ^ tb_mul(a[1], 8'h02) ^ tb_mul(a[2], 8'h03) ^ a[3];
               s[111-32*c -: 8] = a[0] ^ a[1] ^ tb_mul(a[2], 8'h02) ^ tb_mul(a[3], 8'h03);
               s[103-32*c -: 8] = tb_mul(a[0], 8'h03) ^ a[1] ^ a[2] ^ tb_mul(a[3], 8'h02);
            end
         end
         s = s ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      end
      return s;
   endfunction

   // Present a block for one edge, then scramble the inputs to show they are no longer used.
   task automatic start_block(input logic [127:0] ct, input logic [127:0] k);
      ciphertext = ct;
      key        = k;
      start      = 1'b1;
      tick();
      start      = 1'b0;
      ciphertext = ~ct;
      key        = ~k;
   endtask

   // Entered just after the accepting edge; runs the block to completion.
   task automatic finish_block(input logic [127:0] exp, input int exp_lat, input string name);
      int lat;
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL %s busy_after_accept: got %b want 1", name, busy);
      end
      lat = 0;
      do begin
         tick();
         lat++;
      end while (done !== 1'b1 && lat < 40);
      n_cmp++;
      if (lat !== exp_lat) begin
         n_bad++;
         $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
      end
      n_cmp++;
      if (plaintext !== exp) begin
         n_bad++;
         $display("FAIL %s plaintext: got %h want %h", name, plaintext, exp);
      end
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL %s busy_in_done_cycle: got %b want 1", name, busy);
      end
      tick();
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL %s after_done: got done=%b busy=%b want 0 0", name, done, busy);
      end
   endtask

   task automatic test_reset();
      rst        = 1'b0;
      start      = 1'b1;
      ciphertext = C1_CT;
      key        = C1_KEY;
      tick();
      tick();
      tick();
      n_cmp++;
      if (plaintext !== 128'h0 || done !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_outputs: got pt=%h done=%b busy=%b want 0", plaintext, done, busy);
      end
      n_cmp++;
      if (dut.rk_q[10] !== 128'h0) begin
         n_bad++;
         $display("FAIL reset_rk10: got %h want 0", dut.rk_q[10]);
      end
      start = 1'b0;
      rst   = 1'b1;
      tick();
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_idle_busy: got %b want 0", busy);
      end
   endtask

   task automatic test_fips_c1();
      start_block(C1_CT, C1_KEY);
      finish_block(C1_PT, 21, "fips_c1");
   endtask

   task automatic test_fips_b();
      start_block(B_CT, B_KEY);
      finish_block(B_PT, 21, "fips_b");
      n_cmp++;
      if (dut.rk_q[10] !== B_RK10) begin
         n_bad++;
         $display("FAIL fips_b_rk10: got %h want %h", dut.rk_q[10], B_RK10);
      end
   endtask

   task automatic test_start_while_busy();
      int           n_done, done_edge;
      logic [127:0] pt_at_done;
      n_done     = 0;
      done_edge  = -1;
      pt_at_done = '0;
      start_block(C1_CT, C1_KEY);
      ciphertext = B_CT;
      key        = B_KEY;
      for (int e = 1; e <= 22; e++) begin
         start = (e == 5 || e == 21 || e == 22);
         tick();
         if (done === 1'b1) begin
            n_done++;
            done_edge  = e;
            pt_at_done = plaintext;
         end
      end
      start      = 1'b0;
      ciphertext = '0;
      key        = '0;
      n_cmp++;
      if (n_done !== 1 || done_edge !== 21) begin
         n_bad++;
         $display("FAIL busy_start_done: got %0d pulses last at edge %0d want 1 at 21", n_done, done_edge);
      end
      n_cmp++;
      if (pt_at_done !== C1_PT) begin
         n_bad++;
         $display("FAIL busy_start_plaintext: got %h want %h", pt_at_done, C1_PT);
      end
      finish_block(B_PT, 21, "start_at_edge22");
   endtask

   task automatic test_reset_mid_run();
      int n_done;
      n_done = 0;
      start_block(C1_CT, C1_KEY);
      for (int e = 1; e <= 11; e++) tick();
      #2;
      rst = 1'b0;
      #1;
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0 || plaintext !== 128'h0) begin
         n_bad++;
         $display("FAIL midrun_reset: got done=%b busy=%b pt=%h want 0", done, busy, plaintext);
      end
      tick();
      tick();
      rst = 1'b1;
      for (int e = 0; e < 30; e++) begin
         tick();
         if (done === 1'b1) n_done++;
      end
      n_cmp++;
      if (n_done !== 0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL midrun_no_done: got %0d pulses busy=%b want 0 0", n_done, busy);
      end
      start_block(C1_CT, C1_KEY);
      finish_block(C1_PT, 21, "after_reset");
   endtask

   task automatic test_loopback();
      logic [127:0] ct;
      ct = tb_encrypt(LB_PT, LB_KEY);
      start_block(ct, LB_KEY);
      finish_block(LB_PT, 21, "loopback");
   endtask

   task automatic test_keyreuse();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      start_block(C1_CT, C1_KEY);
      finish_block(C1_PT, 21, "reuse_first");
      start_block(C1_CT, C1_KEY);
      finish_block(C1_PT, REUSE_LAT, "reuse_same_key");
      start_block(B_CT, B_KEY);
      finish_block(B_PT, 21, "reuse_new_key");
   endtask

   initial begin
      n_cmp      = 0;
      n_bad      = 0;
      rst        = 1'b0;
      start      = 1'b0;
      ciphertext = '0;
      key        = '0;
      build_sbox();
      test_reset();
      test_fips_c1();
      test_fips_b();
      test_start_while_busy();
      test_reset_mid_run();
      test_loopback();
      test_keyreuse();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
